// File: rtl/float_accumulator_if.sv
// Stream interface of float_accumulator: fp32 element input and vector-sum result output.
// master drives elements and takes results; slave is the accumulator.
interface float_accumulator_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/float_accumulator.sv
// fp32 dot-product reduction stage: one element every 5 cycles through ALIGN/ADD/NORM/ROUND.
// Optional macro FACC_ROUND_NEAREST_EN selects round-to-nearest-even (default: round-toward-zero).
module float_accumulator #(
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    float_accumulator_if.slave  bus
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        op_q, op_d;
    logic               last_q, last_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_val_q, spec_val_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [26:0]        big_q, big_d;
    logic [26:0]        small_q, small_d;
    logic               sub_q, sub_d;
    logic [27:0]        sum_q, sum_d;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic found;
        lzc27 = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      lzc27 = lzc27 + 5'd1;
            end
        end
    endfunction

    // Unpack and align: acc_q against the latched operand op_q
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, a_big, small_zero;
    logic [30:0] key_a, key_b;
    logic [7:0]  big_exp, small_exp, exp_diff;
    logic [22:0] big_frac, small_frac;
    logic [26:0] small_ext, small_shift, small_lost, al_small;
    logic        al_spec;
    logic [31:0] al_spec_val;

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        a_zero      = (acc_q[30:23] == 8'h00);
        a_inf       = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] == 23'd0);
        a_nan       = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] != 23'd0);
        b_zero      = (op_q[30:23] == 8'h00);
        b_inf       = (op_q[30:23] == 8'hFF) && (op_q[22:0] == 23'd0);
        b_nan       = (op_q[30:23] == 8'hFF) && (op_q[22:0] != 23'd0);
        key_a       = a_zero ? 31'd0 : acc_q[30:0];
        key_b       = b_zero ? 31'd0 : op_q[30:0];
        a_big       = (key_a >= key_b);
        big_exp     = a_big ? acc_q[30:23] : op_q[30:23];
        big_frac    = a_big ? acc_q[22:0]  : op_q[22:0];
        small_exp   = a_big ? op_q[30:23]  : acc_q[30:23];
        small_frac  = a_big ? op_q[22:0]   : acc_q[22:0];
        small_zero  = a_big ? b_zero : a_zero;
        exp_diff    = big_exp - small_exp;
        small_ext   = small_zero ? 27'd0 : {1'b1, small_frac, 3'b000};
        small_shift = '0;
        small_lost  = '0;
        if (exp_diff >= 8'd26) begin
            al_small = {26'd0, |small_ext};
        end else begin
            small_shift = small_ext >> exp_diff[4:0];
            small_lost  = small_ext & ((27'd1 << exp_diff[4:0]) - 27'd1);
            al_small    = {small_shift[26:1], small_shift[0] | (|small_lost)};
        end

        al_spec     = 1'b1;
        al_spec_val = 32'd0;
        if (a_nan || b_nan)        al_spec_val = QNAN;
        else if (a_inf && b_inf)   al_spec_val = (acc_q[31] != op_q[31]) ? QNAN : acc_q;
        else if (a_inf)            al_spec_val = acc_q;
        else if (b_inf)            al_spec_val = op_q;
        else if (a_zero && b_zero) al_spec_val = {acc_q[31] & op_q[31], 31'd0};
        else                       al_spec     = 1'b0;
    end

    // Normalisation and rounding helpers
    logic [4:0]        norm_lz;
    logic signed [9:0] norm_exp;
    logic              rnd_inc;
    logic [24:0]       rnd_sum;
    logic signed [9:0] rnd_exp;
    logic [22:0]       rnd_frac;
    logic [31:0]       rnd_result;

    always_comb begin
        norm_lz  = lzc27(sum_q[26:0]);
        norm_exp = exp_q - signed'({5'd0, norm_lz});
`ifdef FACC_ROUND_NEAREST_EN
        rnd_inc  = big_q[2] & (big_q[1] | big_q[0] | big_q[3]);
`else
        rnd_inc  = 1'b0;
`endif
        rnd_sum  = {1'b0, big_q[26:3]} + {24'd0, rnd_inc};
        rnd_exp  = rnd_sum[24] ? exp_q + 10'sd1 : exp_q;
        rnd_frac = rnd_sum[24] ? rnd_sum[23:1] : rnd_sum[22:0];
        if (spec_q) begin
            rnd_result = spec_val_q;
        end else if (rnd_exp >= 10'sd255) begin
`ifdef FACC_ROUND_NEAREST_EN
            rnd_result = {sign_q, 31'h7F80_0000};
`else
            rnd_result = {sign_q, 31'h7F7F_FFFF};
`endif
        end else begin
            rnd_result = {sign_q, rnd_exp[7:0], rnd_frac};
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        count_d       = count_q;
        op_d          = op_q;
        last_d        = last_q;
        spec_d        = spec_q;
        spec_val_d    = spec_val_q;
        sign_d        = sign_q;
        exp_d         = exp_q;
        big_d         = big_q;
        small_d       = small_q;
        sub_d         = sub_q;
        sum_d         = sum_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 32'd0;
        bus.out_count = '0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    op_d   = bus.in_data;
                    last_d = bus.in_last;
                    if (count_q != {CNT_W{1'b1}}) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                spec_d     = al_spec;
                spec_val_d = al_spec_val;
                sign_d     = a_big ? acc_q[31] : op_q[31];
                exp_d      = signed'({2'b00, big_exp});
                big_d      = {1'b1, big_frac, 3'b000};
                small_d    = al_small;
                sub_d      = acc_q[31] ^ op_q[31];
                state_d    = S_ADD;
            end
            S_ADD: begin
                sum_d   = sub_q ? {1'b0, big_q} - {1'b0, small_q} : {1'b0, big_q} + {1'b0, small_q};
                state_d = S_NORM;
            end
            S_NORM: begin
                // big_q is reused to carry the normalised mantissa with G/R/S into ROUND
                if (!spec_q) begin
                    if (sum_q == 28'd0) begin
                        spec_d     = 1'b1;
                        spec_val_d = 32'd0;
                    end else if (sum_q[27]) begin
                        big_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
                        exp_d = exp_q + 10'sd1;
                    end else if (norm_exp <= 10'sd0) begin
                        spec_d     = 1'b1;
                        spec_val_d = {sign_q, 31'd0};
                    end else begin
                        big_d = sum_q[26:0] << norm_lz;
                        exp_d = norm_exp;
                    end
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                acc_d   = rnd_result;
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc_q;
                bus.out_count = count_q;
                if (bus.out_ready) begin
                    acc_d   = 32'd0;
                    count_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; every register is reset so a
    // reset mid-add leaves no partial sum behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= 32'd0;
            count_q    <= '0;
            op_q       <= 32'd0;
            last_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= 32'd0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            big_q      <= '0;
            small_q    <= '0;
            sub_q      <= 1'b0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            op_q       <= op_d;
            last_q     <= last_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            big_q      <= big_d;
            small_q    <= small_d;
            sub_q      <= sub_d;
            sum_q      <= sum_d;
        end
    end

endmodule
